// File: rtl/pe_network_interface_pkg.sv
// Shared NoC definitions: flit width, head-flit field layout and NI state encoding.
package pe_network_interface_pkg;

    localparam int FLIT_W    = 32;

    localparam int DST_X_LSB = 28;
    localparam int DST_X_W   = 4;
    localparam int DST_Y_LSB = 24;
    localparam int DST_Y_W   = 4;
    localparam int SRC_X_LSB = 20;
    localparam int SRC_X_W   = 4;
    localparam int SRC_Y_LSB = 16;
    localparam int SRC_Y_W   = 4;
    localparam int LEN_LSB   = 8;
    localparam int LEN_W     = 8;
    localparam int SEQ_LSB   = 0;
    localparam int SEQ_W     = 8;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_HEAD = 2'd1,
        ST_BODY = 2'd2
    } ni_state_t;

    function automatic logic [FLIT_W-1:0] make_head(
        input logic [DST_X_W-1:0] dst_x,
        input logic [DST_Y_W-1:0] dst_y,
        input logic [SRC_X_W-1:0] src_x,
        input logic [SRC_Y_W-1:0] src_y,
        input logic [LEN_W-1:0]   len,
        input logic [SEQ_W-1:0]   seq
    );
        logic [FLIT_W-1:0] flit;
        flit = '0;
        flit[DST_X_LSB +: DST_X_W] = dst_x;
        flit[DST_Y_LSB +: DST_Y_W] = dst_y;
        flit[SRC_X_LSB +: SRC_X_W] = src_x;
        flit[SRC_Y_LSB +: SRC_Y_W] = src_y;
        flit[LEN_LSB   +: LEN_W]   = len;
        flit[SEQ_LSB   +: SEQ_W]   = seq;
        return flit;
    endfunction

endpackage

// File: rtl/pe_network_interface_if.sv
// PE-side command and payload channels of the injection network interface.
interface pe_network_interface_if;
    import pe_network_interface_pkg::*;

    // Valid/ready: a transfer happens on a rising edge where both are high;
    // the master holds valid and its payload stable until that edge.
    logic              pe_cmd_valid;
    logic              pe_cmd_ready;
    logic [3:0]        pe_dst_x;
    logic [3:0]        pe_dst_y;
    logic [7:0]        pe_len;
    logic              pe_data_valid;
    logic              pe_data_ready;
    logic [FLIT_W-1:0] pe_data;

    modport master (
        output pe_cmd_valid, pe_dst_x, pe_dst_y, pe_len, pe_data_valid, pe_data,
        input  pe_cmd_ready, pe_data_ready
    );

    modport slave (
        input  pe_cmd_valid, pe_dst_x, pe_dst_y, pe_len, pe_data_valid, pe_data,
        output pe_cmd_ready, pe_data_ready
    );

endinterface

// File: rtl/ni_fifo.sv
// Synchronous FIFO with power-of-two depth; shared by the NI payload path and router inports.
module ni_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_data,
    output logic             full,
    output logic             empty
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;

    // Extra pointer bit tells a full buffer apart from an empty one.
    assign empty    = (wr_ptr == rd_ptr);
    assign full     = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign pop_data = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push && !full) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop && !empty) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push && !full) begin
            mem[wr_ptr[AW-1:0]] <= push_data;
        end
    end

endmodule

// File: rtl/pe_network_interface.sv
// Injection NI: turns a PE command plus payload stream into head/body flits, paced by router credits.
module pe_network_interface
    import pe_network_interface_pkg::*;
#(
    parameter logic [3:0] XCOR       = 4'd2,
    parameter logic [3:0] YCOR       = 4'd2,
    parameter int         CREDITS    = 4,
    parameter int         FIFO_DEPTH = 4
) (
    input  logic                           clk,
    input  logic                           rst,
    pe_network_interface_if.slave          pe,
    input  logic                           crt_in,
    output logic                           diff_pair_p,
    output logic                           diff_pair_n,
    output logic [FLIT_W-1:0]              output_channel,
    output logic                           credit_err,
    output ni_state_t                      state,
    output logic [$clog2(CREDITS+1)-1:0]   credit_count
);
    localparam int                CW       = $clog2(CREDITS+1);
    localparam logic [CW-1:0]     CRED_MAX = CW'(CREDITS);

    logic [3:0]        dst_x_q;
    logic [3:0]        dst_y_q;
    logic [7:0]        len_q;
    logic [7:0]        seq_q;
    logic [7:0]        seq;
    logic [7:0]        remain;
    logic              cmd_ready;
    logic [CW-1:0]     credits;
    logic              fifo_full;
    logic              fifo_empty;
    logic [FLIT_W-1:0] fifo_data;
    logic              have_credit;
    logic              send_head;
    logic              send_body;
    logic              send;

    assign have_credit      = (credits != '0);
    assign send_head        = (state == ST_HEAD) && have_credit;
    assign send_body        = (state == ST_BODY) && have_credit && !fifo_empty;
    assign send             = send_head || send_body;
    assign pe.pe_cmd_ready  = cmd_ready;
    assign pe.pe_data_ready = !fifo_full;
    assign credit_count     = credits;

    ni_fifo #(
        .WIDTH (FLIT_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (pe.pe_data_valid),
        .push_data (pe.pe_data),
        .pop       (send_body),
        .pop_data  (fifo_data),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state          <= ST_IDLE;
            cmd_ready      <= 1'b0;
            dst_x_q        <= '0;
            dst_y_q        <= '0;
            len_q          <= '0;
            seq_q          <= '0;
            seq            <= '0;
            remain         <= '0;
            diff_pair_p    <= 1'b0;
            diff_pair_n    <= 1'b1;
            output_channel <= '0;
        end else begin
            diff_pair_p <= send;
            diff_pair_n <= !send;
            case (state)
                ST_IDLE: begin
                    cmd_ready <= 1'b1;
                    if (cmd_ready && pe.pe_cmd_valid) begin
                        dst_x_q   <= pe.pe_dst_x;
                        dst_y_q   <= pe.pe_dst_y;
                        len_q     <= pe.pe_len;
                        seq_q     <= seq;
                        cmd_ready <= 1'b0;
                        state     <= ST_HEAD;
                    end
                end
                ST_HEAD: begin
                    if (send_head) begin
                        output_channel <= make_head(dst_x_q, dst_y_q, XCOR, YCOR, len_q, seq_q);
                        seq            <= seq + 8'd1;
                        if (len_q == 8'd0) begin
                            cmd_ready <= 1'b1;
                            state     <= ST_IDLE;
                        end else begin
                            remain <= len_q;
                            state  <= ST_BODY;
                        end
                    end
                end
                ST_BODY: begin
                    if (send_body) begin
                        output_channel <= fifo_data;
                        remain         <= remain - 8'd1;
                        if (remain == 8'd1) begin
                            cmd_ready <= 1'b1;
                            state     <= ST_IDLE;
                        end
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    // A return that coincides with a send cancels out; a return into a full counter is an error.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            credits    <= CRED_MAX;
            credit_err <= 1'b0;
        end else begin
            case ({send, crt_in})
                2'b10: credits <= credits - 1'b1;
                2'b01: begin
                    if (credits == CRED_MAX) begin
                        credit_err <= 1'b1;
                    end else begin
                        credits <= credits + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: doc/pe_network_interface.md
# pe_network_interface

Injection-side network interface between a processing element (PE) and the router's PE input channel (port 4). It accepts a packet command (destination, length) and a stream of 32-bit payload words, builds one head flit followed by body flits, and drives them onto the router input channel. Flits are sent only while credits are available; the router returns credits on `crt_in`.

## Interface
- `XCOR`, default 2: source X coordinate inserted into every head flit.
- `YCOR`, default 2: source Y coordinate inserted into every head flit.
- `CREDITS`, default 4: router input buffer depth; this is the credit counter reset value.
- `FIFO_DEPTH`, default 4: payload FIFO depth, power of two, at least 2.

Ports:
- `clk` input 1: single clock; all state changes on the rising edge.
- `rst` input 1: asynchronous, active-low reset.
- `pe_cmd_valid` input 1: PE offers a packet command.
- `pe_cmd_ready` output 1: the NI accepts the command.
- `pe_dst_x` input 4: destination X.
- `pe_dst_y` input 4: destination Y.
- `pe_len` input 8: number of body flits, 0..255.
- `pe_data_valid` input 1: PE offers a payload word.
- `pe_data_ready` output 1: payload FIFO not full.
- `pe_data` input 32: payload word.
- `crt_in` input 1: one-cycle credit-return pulse from the router.
- `diff_pair_p` output 1: flit strobe, true half.
- `diff_pair_n` output 1: flit strobe, complement half.
- `output_channel` output 32: flit to the router.
- `credit_err` output 1: sticky flag, set on credit overflow.

## Operation
- Head flit format:
  - [31:28] destination X, [27:24] destination Y.
  - [23:20] source X (`XCOR`), [19:16] source Y (`YCOR`).
  - [15:8] `pe_len`, [7:0] sequence number.
- Body flits carry the payload words unmodified, in arrival order.
- Flit strobe: a flit is valid when `diff_pair_p`=1 and `diff_pair_n`=0. Idle is `diff_pair_p`=0 and `diff_pair_n`=1. The pair is never 1/1 or 0/0.
- Payload FIFO:
  - Push when `pe_data_valid` and `pe_data_ready`. `pe_data_ready` is the inverse of full.
  - Pushes are independent of FSM state, so payload may arrive before the command.
  - A pop in the same cycle does not unblock a push into a full FIFO.
- FSM, states IDLE, HEAD, BODY:
  - IDLE: `pe_cmd_ready`=1. On `pe_cmd_valid`, register dst, len and seq, then go to HEAD.
  - HEAD: when credits > 0, emit the head flit and decrement credits. If len=0, go to IDLE; otherwise load the remaining count with len and go to BODY.
  - BODY: when credits > 0 and the FIFO is not empty, pop and emit one body flit and decrement credits and the remaining count. After the last body flit, go to IDLE.
  - In any cycle where no flit is emitted, the strobe is idle.
- Sequence number: increments by 1 after each head flit; wraps 255→0.
- Credit counter:
  - Width is clog2(CREDITS+1).
  - Send without `crt_in`: decrement. `crt_in` without send: increment. Both in the same cycle: unchanged.
  - `crt_in` while the counter equals CREDITS with no send: the counter saturates and `credit_err` sets. `credit_err` clears only on reset.
- Reset asserted mid-packet: the packet is abandoned, FIFO contents are discarded, and no partial-packet recovery takes place.

## Timing
- Reset values:
  - `diff_pair_p`=0, `diff_pair_n`=1, `output_channel`=0.
  - `pe_cmd_ready`=0 while `rst` is low, 1 from the first edge after release (IDLE).
  - `pe_data_ready`=1 after release, `credit_err`=0.
  - Credits = CREDITS, seq=0.
- Flit outputs are registered.
- Command accepted at edge N: the head flit is visible after edge N+1 when credits are available.
- Body flits follow back-to-back, one per cycle, when credits and data allow.
- With the FIFO prefilled, a packet of L body flits occupies edges N+1..N+1+L.
- The next command is accepted at the edge after the last flit of the previous packet, so the minimum gap between packets is one idle cycle.
- A credit returned at edge M is usable for a send at edge M+1. The counter is updated at M and read for the send decision at M+1.

## Structure
- Shared NoC package holds:
  - Head-flit field offsets and widths (DST_X, DST_Y, SRC_X, SRC_Y, LEN, SEQ).
  - The IDLE/HEAD/BODY state encoding.
  - The flit width constant 32.
- Sub-module `ni_fifo`: synchronous FIFO with parameter depth, push/pop, full/empty, and asynchronous active-low reset. The router inport buffer reuses the same module.

## Test plan
- Reset release, command (x=1, y=3, len=2) with payload 0xA0, 0xA1 prefilled:
  - Head 0x1322_0200 after N+1, then 0xA0, then 0xA1 on consecutive cycles.
  - Credits end at 1.
- CREDITS=4, len=6, no `crt_in`:
  - Head and 3 body flits go out, then the strobe idles.
  - Each later `crt_in` pulse releases exactly one flit, one cycle after the pulse.
- `crt_in` coincident with a send, with credits=2: credits stay at 2.
- `crt_in` with credits=4 and the NI idle: credits stay at 4 and `credit_err`=1 from the next cycle.
- 257 commands with len=0:
  - Each is a single head flit.
  - Sequence runs 0..255, then 0; one idle cycle between heads.
- Reset asserted during BODY:
  - Outputs return to their reset values immediately.
  - After release the FIFO is empty, `pe_cmd_ready`=1 and seq=0.
